// File: rtl/cpu_bus_master.sv
// Bus master for a phi2-clocked CPU-style bus: one access per request,
// bank multiplexed on the data bus in phase 1, wait states via rdy in phase 2.
module cpu_bus_master #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        internal_reset,
  input  logic        req,
  input  logic        req_rw,
  input  logic        req_vp,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        phi2,
  output logic [15:0] address,
  output logic        rw,
  output logic        vp,
  inout  wire  [7:0]  data,
  input  logic        rdy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1A,
    S_P1B,
    S_P2A,
    S_P2B,
    S_DONE
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        cap_rw_q, cap_rw_d;
  logic        cap_vp_q, cap_vp_d;
  logic [23:0] cap_addr_q, cap_addr_d;
  logic [7:0]  cap_wdata_q, cap_wdata_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic        phi2_q, phi2_d;
  logic [15:0] address_q, address_d;
  logic        rw_q, rw_d;
  logic        vp_q, vp_d;
  logic        data_oe_q, data_oe_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;

  always_comb begin
    state_d     = state_q;
    cap_rw_d    = cap_rw_q;
    cap_vp_d    = cap_vp_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          cap_rw_d    = req_rw;
          cap_vp_d    = req_vp;
          cap_addr_d  = req_addr;
          cap_wdata_d = req_wdata;
          state_d     = S_P1A;
        end
      end
      S_P1A: state_d = S_P1B;
      S_P1B: begin
        wait_cnt_d = 8'd0;
        state_d    = S_P2A;
      end
      S_P2A: state_d = S_P2B;
      S_P2B: begin
        if (rdy) begin
          if (cap_rw_q) rdata_d = data;
          state_d = S_DONE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Timed out: finish with err and leave rdata untouched.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are derived from the next state so that every pin is a flop.
  always_comb begin
    phi2_d     = 1'b0;
    address_d  = address_q;
    rw_d       = cap_rw_d;
    vp_d       = ~cap_vp_d;
    data_oe_d  = 1'b0;
    data_out_d = data_out_q;
    busy_d     = (state_d != S_IDLE);
    ack_d      = (state_d == S_DONE);

    case (state_d)
      S_IDLE: begin
        rw_d = 1'b1;
        vp_d = 1'b1;
      end
      S_P1A, S_P1B: begin
        address_d  = cap_addr_d[15:0];
        data_oe_d  = 1'b1;
        data_out_d = cap_addr_d[23:16];
      end
      S_P2A, S_P2B: begin
        phi2_d     = 1'b1;
        data_oe_d  = ~cap_rw_d;
        data_out_d = cap_wdata_d;
      end
      S_DONE: begin
        data_oe_d  = ~cap_rw_d;
        data_out_d = cap_wdata_d;
      end
      default: begin
        rw_d = 1'b1;
        vp_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge internal_reset) begin
    if (internal_reset) begin
      state_q     <= S_IDLE;
      cap_rw_q    <= 1'b1;
      cap_vp_q    <= 1'b0;
      cap_addr_q  <= 24'd0;
      cap_wdata_q <= 8'd0;
      wait_cnt_q  <= 8'd0;
      phi2_q      <= 1'b0;
      address_q   <= 16'd0;
      rw_q        <= 1'b1;
      vp_q        <= 1'b1;
      data_oe_q   <= 1'b0;
      data_out_q  <= 8'd0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cap_rw_q    <= cap_rw_d;
      cap_vp_q    <= cap_vp_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      phi2_q      <= phi2_d;
      address_q   <= address_d;
      rw_q        <= rw_d;
      vp_q        <= vp_d;
      data_oe_q   <= data_oe_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign data    = data_oe_q ? data_out_q : 8'hzz;
  assign phi2    = phi2_q;
  assign address = address_q;
  assign rw      = rw_q;
  assign vp      = vp_q;
  assign busy    = busy_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Scoreboard bench for cpu_bus_master: a driver pushes expected access
// timelines, a negedge monitor checks every bus cycle and each ack.
module tb_cpu_bus_master;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        internal_reset = 1'b1;
  logic        req = 1'b0;
  logic        req_rw = 1'b1;
  logic        req_vp = 1'b0;
  logic [23:0] req_addr = 24'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        rdy = 1'b0;
  logic        busy, ack, err, phi2, rw, vp;
  logic [7:0]  rdata;
  logic [15:0] address;
  wire  [7:0]  data;

  logic [7:0]  cur_resp = 8'd0;
  int          cur_waits = 0;

  // Responder: drives read data whenever the bus is in phase 2 of a read.
  assign data = (phi2 && rw) ? cur_resp : 8'hzz;

  cpu_bus_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .internal_reset(internal_reset), .req(req), .req_rw(req_rw),
    .req_vp(req_vp), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .ack(ack), .err(err), .rdata(rdata), .phi2(phi2),
    .address(address), .rw(rw), .vp(vp), .data(data), .rdy(rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rw;
    bit          vp;
    logic [23:0] addr;
    logic [7:0]  wdata;
    int          lat;
    bit          err;
    logic [7:0]  rdata;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  model_rdata = 8'd0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // rdy low for cur_waits phase-2 wait cycles, then high.
  int p2_idx = -1;
  always @(negedge clk) begin
    if (phi2) p2_idx = p2_idx + 1;
    else      p2_idx = -1;
    rdy = phi2 && (p2_idx > cur_waits);
  end

  // Monitor
  longint cyc_now = 0;
  longint last_ack = 0;
  bit     in_acc = 1'b0;
  int     acc_cyc = 0;
  exp_t   cur;
  logic [7:0] last_rdata = 8'd0;
  logic   exp_oe;

  always @(negedge clk) begin
    cyc_now++;
    if (!mon_en) begin
      in_acc     = 1'b0;
      last_rdata = model_rdata;
    end else begin
      if (!in_acc && busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access actual=busy required=idle at %0t", $time);
        end else begin
          cur     = sb[0];
          in_acc  = 1'b1;
          acc_cyc = 0;
        end
      end
      if (in_acc) begin
        acc_cyc++;
        chk("bus_fields", {address, rw, vp}, {cur.addr[15:0], cur.rw, ~cur.vp});
        chk("phi2", phi2, (acc_cyc >= 3 && acc_cyc < cur.lat));
        chk("busy", busy, 1'b1);
        chk("ack", ack, (acc_cyc == cur.lat));
        exp_oe = (acc_cyc <= 2) ? 1'b1 : ~cur.rw;
        chk("data_oe", dut.data_oe_q, exp_oe);
        if (exp_oe && dut.data_oe_q)
          chk("data_val", data, (acc_cyc <= 2) ? cur.addr[23:16] : cur.wdata);
        if (!ack) chk("err_without_ack", err, 1'b0);
        if (ack) begin
          chk("err", err, cur.err);
          chk("rdata", rdata, cur.rdata);
          if (cur.gap != 0) chk("ack_gap", cyc_now - last_ack, cur.gap);
          last_ack   = cyc_now;
          last_rdata = cur.rdata;
          void'(sb.pop_front());
          in_acc = 1'b0;
        end else if (acc_cyc > cur.lat + 20) begin
          chk("ack_timeout", acc_cyc, cur.lat);
          void'(sb.pop_front());
          in_acc = 1'b0;
        end
      end else begin
        chk("idle_bus", {busy, ack, err, phi2, rw, vp, dut.data_oe_q}, 7'b0000110);
        chk("rdata_hold", rdata, last_rdata);
      end
    end
  end

  task automatic issue(bit rw_i, bit vp_i, logic [23:0] a, logic [7:0] wd,
                       logic [7:0] rsp, int waits, bit hold);
    exp_t e;
    int   guard;
    bit   b2b;
    guard = 0;
    while (!(busy == 1'b0 || ack == 1'b1)) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        chk("issue_window_timeout", guard, 0);
        return;
      end
    end
    b2b     = ack;
    e.rw    = rw_i;
    e.vp    = vp_i;
    e.addr  = a;
    e.wdata = wd;
    e.err   = (waits >= TO);
    e.lat   = (waits < TO) ? 5 + waits : 4 + TO;
    if (rw_i && waits < TO) model_rdata = rsp;
    e.rdata = model_rdata;
    e.gap   = b2b ? 1 + e.lat : 0;
    sb.push_back(e);
    req_rw    = rw_i;
    req_vp    = vp_i;
    req_addr  = a;
    req_wdata = wd;
    cur_resp  = rsp;
    cur_waits = waits;
    req       = 1'b1;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    do begin
      @(negedge clk);
      guard++;
    end while (!busy && guard < 100);
    if (guard >= 100) chk("accept_timeout", guard, 0);
    // Scramble the request inputs while busy; they must not disturb the access.
    req_rw    = 1'($urandom);
    req_vp    = 1'($urandom);
    req_addr  = 24'($urandom);
    req_wdata = 8'($urandom);
    req       = hold;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || ack) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", guard, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  guard;
    bit  hold;
    repeat (3) @(negedge clk);
    chk("rst_bus", {busy, ack, err, phi2, rw, vp, dut.data_oe_q}, 7'b0000110);
    chk("rst_addr", address, 16'h0000);
    chk("rst_rdata", rdata, 8'h00);
    internal_reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    issue(1'b1, 1'b0, 24'h12ABCD, 8'h00, 8'hEA, 0, 1'b0);
    issue(1'b0, 1'b0, 24'h00FFFC, 8'h55, 8'h00, 0, 1'b0);
    issue(1'b1, 1'b0, 24'h345678, 8'h00, 8'h3C, 3, 1'b0);
    issue(1'b1, 1'b0, 24'h000100, 8'h00, 8'h99, 100, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    issue(1'b1, 1'b1, 24'h010203, 8'h00, 8'hA1, 0, 1'b1);
    issue(1'b1, 1'b1, 24'h040506, 8'h00, 8'hB2, 0, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);

    // Reset in phase 2A of a write.
    issue(1'b0, 1'b0, 24'h7F1234, 8'hC3, 8'h00, 0, 1'b0);
    guard = 0;
    while (!phi2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("reached_p2a", phi2, 1'b1);
    mon_en = 1'b0;
    internal_reset = 1'b1;
    #1;
    chk("rst_mid_bus", {busy, ack, phi2, rw, dut.data_oe_q}, 5'b00010);
    sb.delete();
    model_rdata = 8'h00;
    repeat (2) @(negedge clk);
    internal_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {busy, ack}, 2'b00);
    end
    chk("post_rst_rdata", rdata, 8'h00);
    mon_en = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      hold = (n == 39) ? 1'b0 : 1'($urandom);
      issue(1'($urandom), 1'($urandom), 24'($urandom), 8'($urandom),
            8'($urandom), int'($urandom_range(0, 6)), hold);
      if (!hold && ($urandom % 2 == 0)) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_master.md
CPU_BUS_MASTER -- requirements
Module: cpu_bus_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, 32, max phi2-high wait cycles (1..255) before the access is aborted.
REQ-002 SHALL have ports:
- clk  in  1  FPGA clock; the only clock.
- internal_reset  in  1  asynchronous, active-high reset.
- req  in  1  access request, level, sampled in IDLE only.
- req_rw  in  1  1 = read, 0 = write.
- req_vp  in  1  1 = vector-pull access.
- req_addr  in  24  {bank, address}.
- req_wdata  in  8  write data.
- busy  out  1  high in every state except IDLE.
- ack  out  1  one-cycle completion pulse.
- err  out  1  timeout flag, valid with ack.
- rdata  out  8  read data, valid at ack.
- phi2  out  1  bus phase clock.
- address  out  16  bus address.
- rw  out  1  bus read/write.
- vp  out  1  vector pull, active low.
- data  inout  8  multiplexed bank/data bus.
- rdy  in  1  responder ready, high = complete.

Function
REQ-003 SHALL register every bus output; no combinational path from any input to any output.
REQ-004 SHALL implement the states IDLE, P1A, P1B, P2A, P2B, DONE.
REQ-005 IDLE: phi2=0, rw=1, vp=1, data released (Z), address holds its last value, busy=0.
REQ-006 IDLE with req=1: capture req_rw, req_vp, req_addr and req_wdata; go to P1A next cycle.
REQ-007 P1A and P1B: phi2=0; address=addr[15:0]; rw=captured rw; vp=~captured vp; data driven with addr[23:16].
REQ-008 P2A: phi2=1; data driven with wdata on a write; data released on a read; next state P2B.
REQ-009 P2B: phi2=1; sample rdy every cycle.
- rdy=1: latch data into rdata on a read; go to DONE.
- rdy=0: increment the wait counter and stay in P2B.
REQ-010 Wait counter SHALL be 8 bits and clear on P2A entry.
- If rdy=0 and counter == TIMEOUT-1: go to DONE with err=1; rdata is not updated.
REQ-011 DONE: phi2=0; ack=1 for exactly this cycle; err=1 only for a timeout; next state IDLE.
- Write: data stays driven with wdata (hold time).
- Read: data released.
REQ-012 Bus fields during DONE SHALL hold their P2B values; rw returns to 1 and vp to 1 on IDLE entry.
REQ-013 Latency: no-wait access = 5 cycles from acceptance (P1A) to ack inclusive; each rdy=0 cycle adds 1.
REQ-014 Back-to-back: req held high SHALL start the next access in the cycle after IDLE; minimum period is 6 cycles.
REQ-015 rdata SHALL hold its value until the next successful read; err SHALL be 0 whenever ack=0.
REQ-016 req_* changes while busy=1 SHALL have no effect on the access in progress.
REQ-017 data SHALL never be driven in IDLE, in P2A/P2B of a read, or in DONE of a read.

Reset
REQ-018 internal_reset high SHALL force IDLE immediately, including mid-access.
REQ-019 Reset values SHALL be: phi2=0, rw=1, vp=1, address=0, data=Z, busy=0, ack=0, err=0, rdata=0, wait counter=0.
REQ-020 The first access after reset release SHALL need req sampled high in IDLE; no access is resumed.

Verification
REQ-021 Read, rdy tied 1, req_addr=0x12ABCD:
- data=0xEA driven by the responder.
- P1A/P1B: data=0x12, address=0xABCD, rw=1.
- ack in cycle 5, rdata=0xEA, err=0.
REQ-022 Write, req_addr=0x00FFFC, wdata=0x55:
- data=0x00 in P1, data=0x55 in P2A..DONE, rw=0.
- data=Z in IDLE after DONE.
REQ-023 Read with rdy low for 3 P2B cycles:
- phi2 high for 5 cycles.
- ack in cycle 8, rdata captured only in the rdy=1 cycle.
REQ-024 rdy tied 0, TIMEOUT=4: ack with err=1 after 4 P2B cycles; rdata unchanged.
REQ-025 internal_reset asserted in P2A of a write: data=Z, phi2=0, rw=1 immediately; no ack.
REQ-026 req held high over two reads with req_vp=1:
- vp=0 during both accesses.
- Accesses start 6 cycles apart, giving two ack pulses 6 cycles apart.
